// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter: request/response handshakes for NUM_REQ lanes.
// Per-lane fields are packed arrays, so lane i occupies bits [k*i+k-1:k*i] of the flat vector.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0][3:0]       req_op;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_a;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0][4:0]       req_shamt;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic [WIDTH-1:0]              rsp_data;
  logic                          rsp_zero;
  logic                          rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, req_shamt, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_shamt, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// One operation in flight: IDLE (grant) -> EXEC (ALU settles) -> RESP (hold until taken).
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_reg_1,
  output logic [WIDTH-1:0] alu_reg_2,
  output logic [3:0]       alu_control,
  output logic [4:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt;
  logic             err_q;
  logic [IDX_W-1:0] win;
  logic             win_vld;
  logic [IDX_W-1:0] cand;
  int               idx;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110,
      4'b0111, 4'b1100, 4'b1111, 4'b1001: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // First valid requester after rr_ptr, wrapping.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDX_W'(idx);
      if (!win_vld && bus.req_valid[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  // Gated by rst_n so no grant is visible while reset is held.
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && rst_n && win_vld) bus.req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= IDX_W'(NUM_REQ - 1);
      gnt           <= '0;
      err_q         <= 1'b0;
      alu_reg_1     <= '0;
      alu_reg_2     <= '0;
      alu_control   <= '0;
      alu_shamt     <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_zero  <= 1'b0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          gnt         <= win;
          alu_reg_1   <= bus.req_a[win];
          alu_reg_2   <= bus.req_b[win];
          alu_shamt   <= bus.req_shamt[win];
          // Unsupported codes never reach the ALU.
          alu_control <= op_legal(bus.req_op[win]) ? bus.req_op[win] : 4'b0000;
          err_q       <= !op_legal(bus.req_op[win]);
          state       <= EXEC;
        end
        EXEC: begin
          bus.rsp_data  <= err_q ? '0 : alu_out;
          bus.rsp_zero  <= err_q | alu_zero;
          bus.rsp_err   <= err_q;
          bus.rsp_valid <= NUM_REQ'(1) << gnt;
          state         <= RESP;
        end
        RESP: if (bus.rsp_ready[gnt]) begin
          bus.rsp_valid <= '0;
          rr_ptr        <= gnt;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A waiting request must not change under the arbiter; withdrawing it is allowed.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.req_valid[i] && !bus.req_ready[i]) |=>
        (!bus.req_valid[i] ||
         $stable({bus.req_op[i], bus.req_a[i], bus.req_b[i], bus.req_shamt[i]})));
  end
endmodule
